// File: rtl/sequential_multiplier_if.sv
// Request/response bundle for the iterative multiplier; the opcode field is named
// mul_type because "type" is a reserved word in SystemVerilog.
interface sequential_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   d;
    logic [2:0]         mul_type;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               busy;

    modport master (
        output in_valid, a, b, c, d, mul_type, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, c, d, mul_type, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/sequential_multiplier.sv
// Iterative shift-add multiply / multiply-accumulate (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL).
// Optional macro SEQ_MUL_EARLY_TERM_EN ends ITER as soon as the remaining multiplier bits are zero.
module sequential_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input logic                    clk,
    input logic                    reset,
    sequential_multiplier_if.slave bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int W2    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    result_q, result_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [2:0]       type_q, type_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             last_iter;
    logic             is_signed_req;

    // Two's-complement magnitude; the most-negative value maps onto 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
        return r;
    endfunction

    function automatic logic [W2-1:0] partial_product(input logic [W2-1:0]             m,
                                                      input logic [BITS_PER_CYCLE-1:0] digit);
        logic [W2-1:0] pp;
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (digit[i]) begin
                pp = pp + (m << i);
            end
        end
        return pp;
    endfunction

    function automatic logic [W2-1:0] fix_result(input logic [W2-1:0]    acc,
                                                 input logic             neg,
                                                 input logic [2:0]       t,
                                                 input logic [WIDTH-1:0] cw,
                                                 input logic [WIDTH-1:0] dw);
        logic [W2-1:0]    p;
        logic [WIDTH-1:0] lo;
        logic [W2-1:0]    r;
        p  = neg ? (~acc + W2'(1)) : acc;
        lo = p[WIDTH-1:0] + cw;
        case (t)
            3'b000:         r = {{WIDTH{1'b0}}, p[WIDTH-1:0]};
            3'b001:         r = {{WIDTH{1'b0}}, lo};
            3'b100, 3'b110: r = p;
            3'b101, 3'b111: r = p + {cw, dw};
            default:        r = '0;
        endcase
        return r;
    endfunction

    assign accept        = bus.in_valid && (state_q == S_IDLE);
    assign is_signed_req = (bus.mul_type[2:1] == 2'b11);

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign last_iter = (cnt_q == CNT_W'(N - 1)) || ((mplier_q >> BITS_PER_CYCLE) == '0);
`else
    assign last_iter = (cnt_q == CNT_W'(N - 1));
`endif

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        mplier_d = mplier_q;
        c_d      = c_q;
        d_d      = d_q;
        type_d   = type_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    type_d = bus.mul_type;
                    c_d    = bus.c;
                    d_d    = bus.d;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (is_signed_req) begin
                        mcand_d  = {{WIDTH{1'b0}}, magnitude(bus.a)};
                        mplier_d = magnitude(bus.b);
                        neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        neg_d    = 1'b0;
                    end
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d    = acc_q + partial_product(mcand_q, mplier_q[BITS_PER_CYCLE-1:0]);
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_q >> BITS_PER_CYCLE;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_result(acc_q, neg_q, type_q, c_q, d_q);
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and the visible result are reset; working registers are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        acc_q    <= acc_d;
        mplier_q <= mplier_d;
        c_q      <= c_d;
        d_q      <= d_d;
        type_q   <= type_d;
        neg_q    <= neg_d;
        cnt_q    <= cnt_d;
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.result    = result_q;
endmodule

// File: tb/tb_sequential_multiplier.sv
// Scoreboard bench for sequential_multiplier: stimulus pushes expected result/latency,
// an independent monitor pops and compares whenever out_valid rises.
`timescale 1ns/1ps
module tb_sequential_multiplier;
    localparam int WIDTH = 32;
    localparam int BPC   = 2;
    localparam int N     = WIDTH / BPC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequential_multiplier_if #(.WIDTH(WIDTH)) bus ();

    sequential_multiplier #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BPC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hold_ready = 0;
    bit   rand_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the architectural meaning of each opcode.
    function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d,
                                               input logic [2:0] t);
        logic [63:0]        ua, ub, r;
        logic signed [63:0] sa, sbv;
        logic [31:0]        lo;
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        case (t)
            3'd0: begin lo = a * b;     r = {32'b0, lo}; end
            3'd1: begin lo = a * b + c; r = {32'b0, lo}; end
            3'd4: r = ua * ub;
            3'd5: r = ua * ub + {c, d};
            3'd6: r = sa * sbv;
            3'd7: r = sa * sbv + {c, d};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [31:0] b, input logic [2:0] t);
`ifdef SEQ_MUL_EARLY_TERM_EN
        logic [31:0] m;
        int top;
        int k;
        m = (t[2:1] == 2'b11 && b[31]) ? (32'd0 - b) : b;
        top = -1;
        for (int i = 0; i < 32; i++) if (m[i]) top = i;
        k = (top + 1 + BPC - 1) / BPC;
        if (k < 1) k = 1;
        return k + 2;
`else
        return N + 2 + 0 * int'({b[0], t[0]});
`endif
    endfunction

    task automatic scramble_inputs();
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.c        = $urandom;
        bus.d        = $urandom;
        bus.mul_type = 3'($urandom);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [2:0] t);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.c = c; bus.d = d; bus.mul_type = t;
        bus.in_valid = 1'b1;
        while (!bus.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                total++; bad++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.res     = ref_result(a, b, c, d, t);
        e.lat     = ref_latency(b, t);
        e.acc_cyc = cyc + 1;
        expq.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (expq.size() != 0 || !bus.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                total++; bad++;
                $display("FAIL drain_timeout: got pending=%0d expected 0", expq.size());
                return;
            end
        end
    endtask

    // Consumer side: out_ready changes just after posedge so negedge sampling sees a settled value.
    initial begin : ready_drv
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid && hold_ready > 0) begin
                bus.out_ready = 1'b0;
                hold_ready--;
            end else begin
                bus.out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial begin : monitor
        bit          seen;
        logic [63:0] held;
        exp_t        e;
        seen = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else begin
                check("busy_vs_in_ready", 64'(bus.busy), 64'(!bus.in_ready));
                if (bus.out_valid) begin
                    if (!seen) begin
                        if (expq.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_output: got %h expected none", bus.result);
                        end else begin
                            e = expq.pop_front();
                            check("result", bus.result, e.res);
                            check("latency", 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                        end
                        held = bus.result;
                        seen = 1;
                    end else begin
                        check("result_stable", bus.result, held);
                    end
                    check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                    if (bus.out_ready) seen = 0;
                end
            end
        end
    end

    initial begin : stimulus
        int          guard;
        logic [31:0] ra, rb;
        logic [2:0]  rt;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0; bus.mul_type = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b100);
        do_op(32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 3'b110);
        do_op(32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 3'b000);
        do_op(32'd7, 32'd6, 32'hFFFF_FFFF, 32'd0, 3'b001);
        do_op(32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        do_op(32'h8000_0000, 32'd5, 32'd0, 32'd0, 3'b110);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 3'b010);
        do_op(32'h0000_0011, 32'h0000_0022, 32'h1, 32'h2, 3'b011);
        do_op(32'hDEAD_BEEF, 32'd1, 32'd0, 32'd0, 3'b100);
        do_op(32'h0000_1234, 32'd0, 32'h5, 32'h6, 3'b101);
        wait_idle();

        // Consumer stall with in_valid pulsed while the result waits.
        hold_ready = 5;
        do_op(32'h0001_2345, 32'h0006_7890, 32'hAAAA_5555, 32'h1357_9BDF, 3'b101);
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reached_done", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            scramble_inputs();
            bus.in_valid = 1'b1;
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        repeat (25) @(negedge clk);

        rand_ready = 1;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(0, 300));
                3: begin ra = 32'h8000_0000; rb = 32'h8000_0000; end
                default: ;
            endcase
            rt = 3'($urandom);
            do_op(ra, rb, $urandom, $urandom, rt);
        end
        rand_ready = 0;
        wait_idle();

        // Reset in the middle of ITER, with in_valid asserted alongside reset.
        do_op(32'h0BAD_F00D, 32'hFFFF_FFFF, 32'd0, 32'd0, 3'b100);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_result", bus.result, 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        expq.delete();
        @(negedge clk);
        check("reset_wins_no_accept", 64'(bus.busy), 64'd0);

        do_op(32'hFFFF_FFF9, 32'h0000_0013, 32'h0000_0001, 32'h0000_0002, 3'b111);
        wait_idle();
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
